nios2_debug_vjtag_host: RTL



---
 rtl/nios2_debug_vjtag_host.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/nios2_debug_vjtag_host.sv
// nios2_debug_vjtag_host
//
// Virtual-JTAG scan initiator for the Nios II debug slave vji_* interface.
// Every accepted command runs one complete scan: UIR, CDR, DR_LEN x SDR,
// E1DR. The scan then returns to IDLE with the captured tdo bits.
// vji_tck is a divided copy of clk: each tck period is TCK_DIV clk cycles
// low followed by TCK_DIV clk cycles high.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   cmd_valid/cmd_ready    scan request handshake (ready only while idle)
//   cmd_ir, cmd_dr         virtual IR value and DR data (shifted LSB first)
//   rsp_valid              one-cycle pulse when a scan completes
//   rsp_dr                 captured tdo bits, LSB first, held until next pulse
//   vji_tck, vji_tdi       generated test clock and serial data out
//   vji_tdo                serial data from the debug slave
//   vji_ir_in              virtual IR, held until the next accepted command
//   vji_uir/cdr/sdr/e1dr   virtual state flags, one-hot or all zero
//   vji_rti                run-test-idle, high only while idle

module nios2_debug_vjtag_host #(
  parameter int DR_LEN  = 38,
  parameter int IR_LEN  = 2,
  parameter int TCK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic              vji_tck,
  output logic              vji_tdi,
  input  logic              vji_tdo,
  output logic [IR_LEN-1:0] vji_ir_in,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_e1dr,
  output logic              vji_rti
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_E1DR
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(TCK_DIV - 1);
  localparam logic [5:0] BIT_LAST  = 6'(DR_LEN - 1);

  state_t            state;
  logic [7:0]        half_cnt;
  logic [5:0]        bit_cnt;
  logic [5:0]        bit_nxt;
  logic              half_done;
  logic [DR_LEN-1:0] dr_latched;
  logic [DR_LEN-1:0] cap_sr;

  assign bit_nxt   = bit_cnt + 6'd1;
  assign half_done = (half_cnt == HALF_LAST);

  // Single sequencer. Outside IDLE, the half-period counter toggles tck
  // every TCK_DIV cycles. On a rising toggle, tdo is captured; the value
  // sampled is the one present before the tck rise. On a falling toggle, the
  // current tck period ends, so the state flags and tdi advance there.
  // Captured bits build up in cap_sr. They are copied to rsp_dr only at
  // completion, so rsp_dr keeps the previous result during a scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      half_cnt   <= 8'd0;
      bit_cnt    <= 6'd0;
      dr_latched <= '0;
      cap_sr     <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_e1dr   <= 1'b0;
      vji_rti    <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state      <= S_UIR;
            cmd_ready  <= 1'b0;
            vji_rti    <= 1'b0;
            vji_uir    <= 1'b1;
            vji_ir_in  <= cmd_ir;
            dr_latched <= cmd_dr;
            half_cnt   <= 8'd0;
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
          end
        end
        default: begin
          if (!half_done) begin
            half_cnt <= half_cnt + 8'd1;
          end else begin
            half_cnt <= 8'd0;
            vji_tck  <= ~vji_tck;
            if (!vji_tck) begin
              if (state == S_SDR) begin
                cap_sr[bit_cnt] <= vji_tdo;
              end
            end else begin
              case (state)
                S_UIR: begin
                  state   <= S_CDR;
                  vji_uir <= 1'b0;
                  vji_cdr <= 1'b1;
                end
                S_CDR: begin
                  state   <= S_SDR;
                  vji_cdr <= 1'b0;
                  vji_sdr <= 1'b1;
                  bit_cnt <= 6'd0;
                  vji_tdi <= dr_latched[0];
                end
                S_SDR: begin
                  if (bit_cnt == BIT_LAST) begin
                    state    <= S_E1DR;
                    vji_sdr  <= 1'b0;
                    vji_e1dr <= 1'b1;
                    vji_tdi  <= 1'b0;
                  end else begin
                    bit_cnt <= bit_nxt;
                    vji_tdi <= dr_latched[bit_nxt];
                  end
                end
                S_E1DR: begin
                  state     <= S_IDLE;
                  vji_e1dr  <= 1'b0;
                  vji_rti   <= 1'b1;
                  cmd_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_dr    <= cap_sr;
                end
                default: begin
                  state <= S_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
